// File: rtl/div_16x8_seq.sv
// 16/8 unsigned restoring divider, one quotient bit per cycle, valid/ready on both sides.
// Optional build macro DIV_APPROX_TRUNC_EN: stop after 12 iterations, quotient low nibble and remainder forced to 0.
module div_16x8_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] dividend,
    input  logic [7:0]  divisor,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] quotient,
    output logic [7:0]  remainder,
    output logic        div_by_zero
);

    localparam int unsigned QW = 16;
    localparam int unsigned DW = 8;
    localparam int unsigned CW = 4;

`ifdef DIV_APPROX_TRUNC_EN
    localparam logic [CW-1:0] LAST_ITER = CW'(11);
`else
    localparam logic [CW-1:0] LAST_ITER = CW'(15);
`endif

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state;
    logic [QW-1:0]  q;
    logic [DW-1:0]  dvsr;
    logic [DW-1:0]  prem;
    logic [CW-1:0]  iter;

    logic [DW:0]    trial;
    logic [DW-1:0]  prem_next;
    logic [QW-1:0]  q_next;

    // One restoring step: the 9-bit trial always leaves a remainder below the divisor, so 8 bits hold it.
    always_comb begin
        trial     = {prem, q[QW-1]};
        q_next    = {q[QW-2:0], 1'b0};
        prem_next = trial[DW-1:0];
        if (trial >= {1'b0, dvsr}) begin
            prem_next = DW'(trial - {1'b0, dvsr});
            q_next[0] = 1'b1;
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    // Zero divisor is resolved on the first CALC cycle, giving a 1-cycle latency.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            q           <= '0;
            dvsr        <= '0;
            prem        <= '0;
            iter        <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        q     <= dividend;
                        dvsr  <= divisor;
                        prem  <= '0;
                        iter  <= '0;
                        state <= CALC;
                    end
                end
                CALC: begin
                    if (dvsr == '0) begin
                        quotient    <= '1;
                        remainder   <= q[DW-1:0];
                        div_by_zero <= 1'b1;
                        state       <= DONE;
                    end else begin
                        q    <= q_next;
                        prem <= prem_next;
                        iter <= iter + CW'(1);
                        if (iter == LAST_ITER) begin
`ifdef DIV_APPROX_TRUNC_EN
                            quotient  <= {q_next[11:0], 4'b0000};
                            remainder <= '0;
`else
                            quotient  <= q_next;
                            remainder <= prem_next;
`endif
                            div_by_zero <= 1'b0;
                            state       <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_div_16x8_seq.sv
// Scoreboard bench for div_16x8_seq: driver pushes expected results, negedge monitor pops and compares.
module tb_div_16x8_seq;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] dividend;
    logic [7:0]  divisor;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] quotient;
    logic [7:0]  remainder;
    logic        div_by_zero;

    div_16x8_seq dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .dividend(dividend), .divisor(divisor),
        .out_valid(out_valid), .out_ready(out_ready),
        .quotient(quotient), .remainder(remainder),
        .div_by_zero(div_by_zero)
    );

`ifdef DIV_APPROX_TRUNC_EN
    localparam int LAT = 12;
`else
    localparam int LAT = 16;
`endif

    typedef struct {
        logic [15:0] q;
        logic [7:0]  r;
        logic        dbz;
        int          lat;
        int          acc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   rise_cyc = 0;
    logic prev_v = 1'b0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Monitor: a result is consumed at the edge after a negedge that sees out_valid && out_ready.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (out_valid && !prev_v) rise_cyc = cyc;
            prev_v = out_valid;
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_result", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("quotient", 32'(quotient), 32'(e.q));
                    chk("remainder", 32'(remainder), 32'(e.r));
                    chk("div_by_zero", 32'(div_by_zero), 32'(e.dbz));
                    chk("latency", 32'(rise_cyc - e.acc), 32'(e.lat));
                end
            end
        end
    end

    task automatic do_op(input logic [15:0] a, input logic [7:0] b, input logic [15:0] eq,
                         input logic [7:0] er, input logic ed, input int lat);
        exp_t e;
        int   n;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            chk("in_ready_timeout", 32'd0, 32'd1);
            return;
        end
        dividend = a;
        divisor  = b;
        in_valid = 1'b1;
        e.q = eq; e.r = er; e.dbz = ed; e.lat = lat; e.acc = cyc + 1;
        sb.push_back(e);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) chk("drain_timeout", 32'(sb.size()), 32'd0);
        @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout actual=%0d cycles required=completion", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        bit          stable;
        int          n;
        logic [15:0] sq;
        logic [7:0]  sr;
        int          a;
        int          b;
        logic [15:0] p;
        logic [15:0] eq;

        rst = 1'b1; in_valid = 1'b0; dividend = '0; divisor = '0; out_ready = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_quotient", 32'(quotient), 32'd0);
        chk("rst_remainder", 32'(remainder), 32'd0);
        chk("rst_dbz", 32'(div_by_zero), 32'd0);

        // Directed exact / truncated vectors.
`ifdef DIV_APPROX_TRUNC_EN
        do_op(16'd1000,  8'd7,   16'd128,   8'd0, 1'b0, LAT);
        do_op(16'hFFFF,  8'd1,   16'd65520, 8'd0, 1'b0, LAT);
        do_op(16'd255,   8'd255, 16'd0,     8'd0, 1'b0, LAT);
        do_op(16'd50000, 8'd200, 16'd240,   8'd0, 1'b0, LAT);
        do_op(16'd12345, 8'd100, 16'd112,   8'd0, 1'b0, LAT);
        do_op(16'd0,     8'd5,   16'd0,     8'd0, 1'b0, LAT);
        do_op(16'h1234,  8'd0,   16'hFFFF,  8'h34, 1'b1, 1);
        do_op(16'd100,   8'd10,  16'd0,     8'd0, 1'b0, LAT);
`else
        do_op(16'd1000,  8'd7,   16'd142,   8'd6,  1'b0, LAT);
        do_op(16'hFFFF,  8'd1,   16'hFFFF,  8'd0,  1'b0, LAT);
        do_op(16'd255,   8'd255, 16'd1,     8'd0,  1'b0, LAT);
        do_op(16'd50000, 8'd200, 16'd250,   8'd0,  1'b0, LAT);
        do_op(16'd12345, 8'd100, 16'd123,   8'd45, 1'b0, LAT);
        do_op(16'd0,     8'd5,   16'd0,     8'd0,  1'b0, LAT);
        do_op(16'h1234,  8'd0,   16'hFFFF,  8'h34, 1'b1, 1);
        do_op(16'd100,   8'd10,  16'd10,    8'd0,  1'b0, LAT);
`endif
        drain();

        // Reset in the middle of CALC: no result, outputs cleared.
        dividend = 16'd1000; divisor = 8'd7; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        chk("midrst_quotient", 32'(quotient), 32'd0);
        stable = 1'b1;
        repeat (24) begin
            @(negedge clk);
            if (out_valid) stable = 1'b0;
        end
        chk("midrst_no_valid", 32'(stable), 32'd1);

        // Back-pressure with operand churn during CALC.
        out_ready = 1'b0;
`ifdef DIV_APPROX_TRUNC_EN
        do_op(16'd40000, 8'd3, 16'd13328, 8'd0, 1'b0, LAT);
`else
        do_op(16'd40000, 8'd3, 16'd13333, 8'd1, 1'b0, LAT);
`endif
        dividend = 16'hFFFF; divisor = 8'd1; in_valid = 1'b1;
        n = 0;
        while (!out_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("bp_valid_seen", 32'(out_valid), 32'd1);
        sq = quotient; sr = remainder;
        stable = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (quotient !== sq || remainder !== sr || in_ready !== 1'b0 || out_valid !== 1'b1)
                stable = 1'b0;
        end
        chk("bp_stable", 32'(stable), 32'd1);
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("bp_in_ready_after", 32'(in_ready), 32'd1);
        drain();

        // Multiplier round trip: (A*B)/B.
        for (int i = 0; i < 1500; i++) begin
            a = int'($urandom_range(1, 255));
            b = int'($urandom_range(1, 255));
            p = 16'(a * b);
`ifdef DIV_APPROX_TRUNC_EN
            eq = 16'(((int'(p) >> 4) / b) << 4);
`else
            eq = 16'(a);
`endif
            do_op(p, 8'(b), eq, 8'd0, 1'b0, LAT);
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
